// File: rtl/types_pkg.sv
// types_pkg: shared FSM state type, mixing constant and byte-rotate helper for the keystream generator
package types_pkg;

   typedef enum logic [2:0] {
      GROUND,
      FIRST_QUERRY,
      READY,
      QUERRIED,
      PULSE_OUT,
      EXHAUSTED
   } hash_generator_state_t;

   localparam logic [7:0] KS_MIX = 8'h1D;

   function automatic logic [7:0] rotl8(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

endpackage

// File: rtl/ks_byte_fn.sv
// ks_byte_fn: combinational keystream byte b_i = rotl8(keybyte[i mod 4] ^ nonce ^ ctr ^ i*KS_MIX, 1)
//   key_i   32  key, byte k at key_i[8k+:8]
//   nonce_i  8  nonce
//   ctr_i    8  block counter
//   idx_i   IW  buffer index i
//   byte_o   8  resulting keystream byte
module ks_byte_fn
   import types_pkg::*;
#(
   parameter int IW = 3
) (
   input  logic [31:0]   key_i,
   input  logic [7:0]    nonce_i,
   input  logic [7:0]    ctr_i,
   input  logic [IW-1:0] idx_i,
   output logic [7:0]    byte_o
);

   logic [7:0] idx8;
   logic [7:0] mix;

   always_comb begin
      idx8   = 8'(idx_i);
      mix    = key_i[{idx_i[1:0], 3'b000} +: 8] ^ nonce_i ^ ctr_i ^ 8'(idx8 * KS_MIX);
      byte_o = rotl8(mix);
   end

endmodule

// File: rtl/keystream_generator.sv
// keystream_generator: buffered keystream responder answering single-cycle byte requests with a valid pulse
//   clk, rst_n        clock, asynchronous active-low reset
//   load_i            latch key_i/nonce_i and restart from GROUND (wins over req_i)
//   key_i, nonce_i    key material
//   req_i             byte request, honoured only while ready_o=1
//   ready_o           high in GROUND or READY
//   byte_o, valid_o   keystream byte (held) and its one-cycle strobe
//   block_ctr_o       current block counter
module keystream_generator
   import types_pkg::*;
#(
   parameter int BUF_BYTES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic [31:0] key_i,
   input  logic [7:0]  nonce_i,
   input  logic        req_i,
   output logic        ready_o,
   output logic [7:0]  byte_o,
   output logic        valid_o,
   output logic [7:0]  block_ctr_o
);

   localparam int IW = $clog2(BUF_BYTES);
   localparam int MW = IW + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BUF_BYTES - 1);

   hash_generator_state_t state_q, state_d;
   logic [31:0]   key_q, key_d;
   logic [7:0]    nonce_q, nonce_d;
   logic [7:0]    ctr_q, ctr_d;
   logic [7:0]    out_q, out_d;
   logic [MW-1:0] marker_q, marker_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          fill_q, fill_d;
   logic [7:0]    buf_q [BUF_BYTES];
   logic [7:0]    buf_d [BUF_BYTES];
   logic [7:0]    ks_byte;

   ks_byte_fn #(.IW(IW)) u_byte_fn (
      .key_i   (key_q),
      .nonce_i (nonce_q),
      .ctr_i   (ctr_q),
      .idx_i   (idx_q),
      .byte_o  (ks_byte)
   );

   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      nonce_d  = nonce_q;
      ctr_d    = ctr_q;
      out_d    = out_q;
      marker_d = marker_q;
      idx_d    = idx_q;
      fill_d   = fill_q;
      buf_d    = buf_q;
      if (load_i) begin
         key_d    = key_i;
         nonce_d  = nonce_i;
         ctr_d    = '0;
         marker_d = '0;
         idx_d    = '0;
         fill_d   = 1'b0;
         state_d  = GROUND;
      end else begin
         case (state_q)
            GROUND:       state_d = req_i ? FIRST_QUERRY : GROUND;
            FIRST_QUERRY: begin
               buf_d[idx_q] = ks_byte;
               idx_d        = idx_q + 1'b1;
               state_d      = (idx_q == LAST_IDX) ? QUERRIED : FIRST_QUERRY;
            end
            READY:        state_d = req_i ? QUERRIED : READY;
            QUERRIED: begin
               out_d   = buf_q[marker_q[IW-1:0]];
               state_d = PULSE_OUT;
            end
            PULSE_OUT: begin
               marker_d = marker_q + 1'b1;
               state_d  = (marker_d == MW'(BUF_BYTES)) ? EXHAUSTED : READY;
            end
            EXHAUSTED: begin
               // first cycle bumps the counter; the following BUF_BYTES cycles refill with it
               if (!fill_q) begin
                  ctr_d  = ctr_q + 1'b1;
                  fill_d = 1'b1;
                  idx_d  = '0;
               end else begin
                  buf_d[idx_q] = ks_byte;
                  idx_d        = idx_q + 1'b1;
                  if (idx_q == LAST_IDX) begin
                     fill_d   = 1'b0;
                     marker_d = '0;
                     state_d  = READY;
                  end
               end
            end
            default:      state_d = GROUND;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= GROUND;
         key_q    <= '0;
         nonce_q  <= '0;
         ctr_q    <= '0;
         out_q    <= '0;
         marker_q <= '0;
         idx_q    <= '0;
         fill_q   <= 1'b0;
         for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         key_q    <= key_d;
         nonce_q  <= nonce_d;
         ctr_q    <= ctr_d;
         out_q    <= out_d;
         marker_q <= marker_d;
         idx_q    <= idx_d;
         fill_q   <= fill_d;
         buf_q    <= buf_d;
      end
   end

   assign ready_o     = (state_q == GROUND) || (state_q == READY);
   assign valid_o     = (state_q == PULSE_OUT);
   assign byte_o      = out_q;
   assign block_ctr_o = ctr_q;

endmodule

// File: tb/tb_keystream_generator.sv
// tb_keystream_generator: randomized self-checking bench against a byte-count reference model
module tb_keystream_generator;

   localparam int B = 8;

   logic        clk = 1'b0;
   logic        rst_n, load_i, req_i, ready_o, valid_o;
   logic [31:0] key_i;
   logic [7:0]  nonce_i, byte_o, block_ctr_o;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_key;
   logic [7:0]  m_nonce;
   int          m_n;

   always #5 clk = ~clk;

   keystream_generator #(.BUF_BYTES(B)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load_i),
      .key_i       (key_i),
      .nonce_i     (nonce_i),
      .req_i       (req_i),
      .ready_o     (ready_o),
      .byte_o      (byte_o),
      .valid_o     (valid_o),
      .block_ctr_o (block_ctr_o)
   );

   // byte number n since load lives in block n/B at index n%B
   function automatic logic [7:0] model_byte(input logic [31:0] k, input logic [7:0] nn, input int n);
      int c  = (n / B) % 256;
      int i  = n % B;
      int kb = int'((k >> (8 * (i % 4))) & 32'hFF);
      int x  = kb ^ int'(nn) ^ c ^ ((i * 29) % 256);
      return 8'(((x * 2) % 256) + x / 128);
   endfunction

   task automatic do_load(input logic [31:0] k, input logic [7:0] nn);
      key_i = k; nonce_i = nn; load_i = 1'b1;
      @(negedge clk);
      load_i = 1'b0;
      m_key = k; m_nonce = nn; m_n = 0;
   endtask

   task automatic do_req(output logic [7:0] b, output int lat);
      int w = 0;
      while (!ready_o && w < 100) begin @(negedge clk); w++; end
      req_i = 1'b1;
      @(negedge clk);
      req_i = 1'b0;
      lat = 1;
      while (!valid_o && lat < 100) begin @(negedge clk); lat++; end
      b = byte_o;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; load_i = 1'b0; req_i = 1'b0; key_i = '0; nonce_i = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || byte_o !== 8'h00 || block_ctr_o !== 8'h00) begin
         failures++;
         $display("FAIL reset: ready=%b valid=%b byte=%h ctr=%h, want 1 0 00 00", ready_o, valid_o, byte_o, block_ctr_o);
      end
      rst_n = 1'b1;
      m_key = '0; m_nonce = '0; m_n = 0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [7:0] exp_b [3] = '{8'h00, 8'h3A, 8'h74};
      int exp_l [3] = '{B + 2, 2, 2};
      logic [7:0] b;
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_req(b, lat);
         checks++;
         if (b !== exp_b[i] || lat != exp_l[i] || block_ctr_o !== 8'h00) begin
            failures++;
            $display("FAIL basic[%0d]: byte=%h lat=%0d ctr=%h, want %h %0d 00", i, b, lat, block_ctr_o, exp_b[i], exp_l[i]);
         end
         m_n++;
      end
   endtask

   task automatic test_load_key;
      logic [7:0] exp_b [2] = '{8'hFF, 8'h3A};
      logic [7:0] b;
      int lat;
      do_load(32'h0000_00FF, 8'h00);
      for (int i = 0; i < 2; i++) begin
         do_req(b, lat);
         checks++;
         if (b !== exp_b[i]) begin
            failures++;
            $display("FAIL load_key[%0d]: byte=%h want %h", i, b, exp_b[i]);
         end
         m_n++;
      end
   endtask

   task automatic test_rollover;
      logic [7:0] b;
      int lat, cnt;
      do_load(32'h0, 8'h00);
      for (int i = 0; i < B; i++) begin
         do_req(b, lat);
         checks++;
         if (b !== model_byte(m_key, m_nonce, m_n)) begin
            failures++;
            $display("FAIL rollover byte %0d: got %h want %h", i, b, model_byte(m_key, m_nonce, m_n));
         end
         m_n++;
      end
      cnt = 0;
      @(negedge clk);
      while (!ready_o && cnt < 50) begin cnt++; @(negedge clk); end
      checks++;
      if (cnt != B + 1) begin
         failures++;
         $display("FAIL rollover ready_low: got %0d cycles want %0d", cnt, B + 1);
      end
      do_req(b, lat);
      checks++;
      if (b !== 8'h02 || block_ctr_o !== 8'h01 || lat != 2) begin
         failures++;
         $display("FAIL rollover 9th: byte=%h ctr=%h lat=%0d, want 02 01 2", b, block_ctr_o, lat);
      end
      m_n++;
   endtask

   task automatic test_ignored_req;
      logic [7:0] b;
      int lat, pulses, w;
      w = 0;
      while (!ready_o && w < 50) begin @(negedge clk); w++; end
      req_i = 1'b1; @(negedge clk);
      req_i = 1'b1; @(negedge clk);
      req_i = 1'b0;
      b = byte_o;
      pulses = int'(valid_o);
      repeat (6) begin @(negedge clk); pulses += int'(valid_o); end
      checks++;
      if (pulses != 1 || b !== model_byte(m_key, m_nonce, m_n)) begin
         failures++;
         $display("FAIL ignored_querried: pulses=%0d byte=%h, want 1 %h", pulses, b, model_byte(m_key, m_nonce, m_n));
      end
      m_n++;
      do_req(b, lat);
      checks++;
      if (b !== model_byte(m_key, m_nonce, m_n)) begin
         failures++;
         $display("FAIL ignored_marker: got %h want %h", b, model_byte(m_key, m_nonce, m_n));
      end
      m_n++;
      while (m_n % B != 0) begin
         do_req(b, lat);
         m_n++;
      end
      pulses = 0;
      w = 0;
      @(negedge clk);
      while (!ready_o && w < 50) begin
         req_i = 1'b1;
         @(negedge clk);
         req_i = 1'b0;
         pulses += int'(valid_o);
         w++;
      end
      req_i = 1'b0;
      checks++;
      if (pulses != 0 || w != B + 1) begin
         failures++;
         $display("FAIL ignored_exhausted: pulses=%0d low=%0d, want 0 %0d", pulses, w, B + 1);
      end
      do_req(b, lat);
      checks++;
      if (b !== model_byte(m_key, m_nonce, m_n) || block_ctr_o !== 8'(m_n / B)) begin
         failures++;
         $display("FAIL ignored_next: byte=%h ctr=%h, want %h %h", b, block_ctr_o, model_byte(m_key, m_nonce, m_n), 8'(m_n / B));
      end
      m_n++;
   endtask

   task automatic test_load_priority;
      logic [7:0] b, held;
      logic [31:0] k;
      int lat, pulses, w;
      w = 0;
      while (!ready_o && w < 50) begin @(negedge clk); w++; end
      held = byte_o;
      k = $urandom;
      key_i = k; nonce_i = 8'h5A; load_i = 1'b1; req_i = 1'b1;
      @(negedge clk);
      load_i = 1'b0; req_i = 1'b0;
      m_key = k; m_nonce = 8'h5A; m_n = 0;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || block_ctr_o !== 8'h00 || byte_o !== held) begin
         failures++;
         $display("FAIL load_priority: valid=%b ready=%b ctr=%h byte=%h, want 0 1 00 %h", valid_o, ready_o, block_ctr_o, byte_o, held);
      end
      pulses = 0;
      repeat (12) begin @(negedge clk); pulses += int'(valid_o); end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL load_priority_pulses: got %0d want 0", pulses);
      end
      do_req(b, lat);
      checks++;
      if (b !== model_byte(m_key, m_nonce, 0) || lat != B + 2) begin
         failures++;
         $display("FAIL load_priority_next: byte=%h lat=%0d, want %h %0d", b, lat, model_byte(m_key, m_nonce, 0), B + 2);
      end
      m_n++;
   endtask

   task automatic test_load_midfill;
      logic [7:0] b, held;
      logic [31:0] k;
      int lat, pulses;
      do_load($urandom, 8'($urandom));
      held = byte_o;
      req_i = 1'b1; @(negedge clk); req_i = 1'b0;
      repeat (3) @(negedge clk);
      k = $urandom;
      do_load(k, 8'hC3);
      checks++;
      if (ready_o !== 1'b1 || block_ctr_o !== 8'h00 || byte_o !== held) begin
         failures++;
         $display("FAIL midfill_state: ready=%b ctr=%h byte=%h, want 1 00 %h", ready_o, block_ctr_o, byte_o, held);
      end
      pulses = 0;
      repeat (14) begin @(negedge clk); pulses += int'(valid_o); end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL midfill_pulses: got %0d want 0", pulses);
      end
      do_req(b, lat);
      checks++;
      if (b !== model_byte(k, 8'hC3, 0) || lat != B + 2) begin
         failures++;
         $display("FAIL midfill_next: byte=%h lat=%0d, want %h %0d", b, lat, model_byte(k, 8'hC3, 0), B + 2);
      end
      m_n++;
   endtask

   task automatic test_async_reset;
      logic [7:0] b;
      int w, lat;
      do_load(32'h1234_5678, 8'h05);
      req_i = 1'b1; @(negedge clk); req_i = 1'b0;
      w = 0;
      while (!valid_o && w < 50) begin @(negedge clk); w++; end
      checks++;
      if (valid_o !== 1'b1 || byte_o !== model_byte(m_key, m_nonce, 0)) begin
         failures++;
         $display("FAIL async_pre: valid=%b byte=%h, want 1 %h", valid_o, byte_o, model_byte(m_key, m_nonce, 0));
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (valid_o !== 1'b0 || byte_o !== 8'h00 || ready_o !== 1'b1 || block_ctr_o !== 8'h00) begin
         failures++;
         $display("FAIL async_reset: valid=%b byte=%h ready=%b ctr=%h, want 0 00 1 00", valid_o, byte_o, ready_o, block_ctr_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_key = '0; m_nonce = '0; m_n = 0;
      @(negedge clk);
      do_req(b, lat);
      checks++;
      if (b !== model_byte(m_key, m_nonce, 0) || lat != B + 2) begin
         failures++;
         $display("FAIL async_resume: byte=%h lat=%0d, want %h %0d", b, lat, model_byte(m_key, m_nonce, 0), B + 2);
      end
      m_n++;
   endtask

   task automatic test_random;
      logic [7:0] b, eb;
      int lat, el;
      for (int r = 0; r < 3; r++) begin
         do_load($urandom, 8'($urandom));
         for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            el = (m_n == 0) ? B + 2 : 2;
            eb = model_byte(m_key, m_nonce, m_n);
            do_req(b, lat);
            checks++;
            if (b !== eb || lat != el || block_ctr_o !== 8'(m_n / B)) begin
               failures++;
               $display("FAIL random[%0d.%0d]: byte=%h lat=%0d ctr=%h, want %h %0d %h", r, i, b, lat, block_ctr_o, eb, el, 8'(m_n / B));
            end
            m_n++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_load_key();
      test_rollover();
      test_ignored_req();
      test_load_priority();
      test_load_midfill();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
